// File: rtl/cdb_ready_table_if.sv
// Bus bundle for the CDB ready scoreboard: dispatch allocations, CDB
// writebacks, rename-side lookups and the status outputs.
interface cdb_ready_table_if #(
  parameter int N_WAY     = 3,
  parameter int PRF_WIDTH = 7
);
  logic                            flush;
  logic [N_WAY-1:0]                alloc_valid;
  logic [N_WAY*PRF_WIDTH-1:0]      alloc_prn;
  logic [N_WAY-1:0]                cdb_valid;
  logic [N_WAY*PRF_WIDTH-1:0]      cdb_tag;
  logic [2*N_WAY*PRF_WIDTH-1:0]    src_prn;
  logic [2*N_WAY-1:0]              src_ready;
  logic [PRF_WIDTH:0]              pending_cnt;
  logic                            err;

  // Pipeline side: drives dispatch/CDB/lookup, observes the scoreboard.
  modport master (
    output flush, alloc_valid, alloc_prn, cdb_valid, cdb_tag, src_prn,
    input  src_ready, pending_cnt, err
  );

  // Scoreboard side.
  modport slave (
    input  flush, alloc_valid, alloc_prn, cdb_valid, cdb_tag, src_prn,
    output src_ready, pending_cnt, err
  );
endinterface

// File: rtl/cdb_ready_table.sv
// Physical-register ready scoreboard. Dispatch clears ready bits, CDB
// writebacks set them, lookups see the table OR'd with a same-cycle CDB
// bypass. Allocation outranks broadcast; flush makes every PRN ready.
module cdb_ready_table #(
  parameter int N_WAY     = 3,
  parameter int PRF_WIDTH = 7,
  parameter int PRF_NUM   = 128
) (
  input  logic               clock,
  input  logic               reset_n,
  cdb_ready_table_if.slave   bus
);
  localparam int CNT_W = PRF_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [PRF_NUM-1:0]   ready_q, ready_d;
  logic [CNT_W-1:0]     pending_q;
  logic                 err_q;

  logic [PRF_WIDTH-1:0] a_tag [N_WAY];
  logic [PRF_WIDTH-1:0] c_tag [N_WAY];
  logic [PRF_WIDTH-1:0] s_tag [2*N_WAY];
  logic [N_WAY-1:0]     alloc_live, cdb_live;
  logic [N_WAY-1:0]     cdb_also_alloc, alloc_also_cdb;
  logic [N_WAY-1:0]     cdb_first, alloc_first;
  logic                 alloc_dup;
  logic [CNT_W-1:0]     s_cnt, c_cnt;
  logic                 err_set;
  logic [2*N_WAY-1:0]   src_ready_d;

  // Decode ways: live means valid and not the zero register; "first" marks
  // the lowest way carrying a tag so duplicates are counted once.
  always_comb begin
    alloc_live     = '0;
    cdb_live       = '0;
    cdb_also_alloc = '0;
    alloc_also_cdb = '0;
    cdb_first      = '1;
    alloc_first    = '1;
    alloc_dup      = 1'b0;
    for (int i = 0; i < N_WAY; i++) begin
      a_tag[i]      = bus.alloc_prn[i*PRF_WIDTH +: PRF_WIDTH];
      c_tag[i]      = bus.cdb_tag[i*PRF_WIDTH +: PRF_WIDTH];
      alloc_live[i] = bus.alloc_valid[i] && (a_tag[i] != '0);
      cdb_live[i]   = bus.cdb_valid[i] && (c_tag[i] != '0);
    end
    for (int i = 0; i < N_WAY; i++) begin
      for (int j = 0; j < N_WAY; j++) begin
        if (alloc_live[j] && (a_tag[j] == c_tag[i])) cdb_also_alloc[i] = 1'b1;
        if (cdb_live[j] && (c_tag[j] == a_tag[i]))   alloc_also_cdb[i] = 1'b1;
        if ((j < i) && cdb_live[j] && (c_tag[j] == c_tag[i])) cdb_first[i] = 1'b0;
        if ((j < i) && alloc_live[j] && (a_tag[j] == a_tag[i])) begin
          alloc_first[i] = 1'b0;
          if (alloc_live[i]) alloc_dup = 1'b1;
        end
      end
    end
  end

  // Next table, count deltas and protocol-error detection.
  always_comb begin
    ready_d = ready_q;
    s_cnt   = '0;
    c_cnt   = '0;
    err_set = alloc_dup;
    for (int i = 0; i < N_WAY; i++) begin
      if (cdb_live[i]) ready_d[c_tag[i]] = 1'b1;
    end
    for (int i = 0; i < N_WAY; i++) begin
      if (alloc_live[i]) ready_d[a_tag[i]] = 1'b0;
    end
    ready_d[0] = 1'b1;
    for (int i = 0; i < N_WAY; i++) begin
      if (cdb_live[i] && cdb_first[i] && !ready_q[c_tag[i]] && !cdb_also_alloc[i])
        s_cnt = s_cnt + CNT_ONE;
      if (alloc_live[i] && alloc_first[i] && ready_q[a_tag[i]])
        c_cnt = c_cnt + CNT_ONE;
      if (cdb_live[i] && ready_q[c_tag[i]] && !cdb_also_alloc[i])
        err_set = 1'b1;
      if (alloc_live[i] && !ready_q[a_tag[i]] && !alloc_also_cdb[i])
        err_set = 1'b1;
    end
  end

  // Lookup ports: table bit, zero register, or same-cycle CDB bypass.
  always_comb begin
    src_ready_d = '0;
    for (int j = 0; j < 2*N_WAY; j++) begin
      s_tag[j]       = bus.src_prn[j*PRF_WIDTH +: PRF_WIDTH];
      src_ready_d[j] = ready_q[s_tag[j]] || (s_tag[j] == '0);
      for (int i = 0; i < N_WAY; i++) begin
        if (bus.cdb_valid[i] && (c_tag[i] == s_tag[j])) src_ready_d[j] = 1'b1;
      end
    end
  end

  // State update: reset, then flush, then normal alloc/broadcast.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_q   <= '1;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else if (bus.flush) begin
      ready_q   <= '1;
      pending_q <= '0;
    end else begin
      ready_q   <= ready_d;
      pending_q <= pending_q - s_cnt + c_cnt;
      if (err_set) err_q <= 1'b1;
    end
  end

  assign bus.src_ready   = src_ready_d;
  assign bus.pending_cnt = pending_q;
  assign bus.err         = err_q;
endmodule
